onenet_loopback_checker: RTL and testbench

Testbench-side stage that drives the single-bit `drive` net of the `ConnectTB` interface (tb modport) and consumes the `observe` net returned by the device under test. Once per run it shifts a WIDTH-bit pattern out on `drive`, LSB first, and samples `observe` after a fixed path latency. It reconstructs the returned word, counts mismatching bits and reports pass/fail. It is the upstream feeder and downstream consumer of the one-net modport path through `dut`/`middle`/`SUB`.

---
 rtl/onenet_loopback_checker.sv | 165 ++++++++++++++++
 tb/tb_onenet_loopback_checker.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/onenet_loopback_checker.sv
// Shifts a WIDTH-bit pattern out on drive (LSB first) and rebuilds the word returned on observe.
// Result arrives WIDTH+LATENCY+1 cycles after the accepted start; start is ignored (not queued) while a run is active.
module onenet_loopback_checker #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           pattern,
    output logic                       drive,
    input  logic                       observe,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [$clog2(WIDTH+1)-1:0] err_count,
    output logic [WIDTH-1:0]           captured
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(WIDTH);
    localparam int DL = (LATENCY > 0) ? LATENCY : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [TW-1:0]    tx_cnt_q, tx_cnt_d;
    logic [TW-1:0]    rx_cnt_q, rx_cnt_d;
    logic [2:0]       drn_cnt_q, drn_cnt_d;
    logic [DL-1:0]    dl_vld_q, dl_vld_d;
    logic [DL-1:0]    dl_exp_q, dl_exp_d;
    logic             drive_q, drive_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CW-1:0]    err_q, err_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             smp_vld, smp_exp;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        drn_cnt_d = drn_cnt_q;
        drive_d   = drive_q;
        pass_d    = pass_q;
        err_d     = err_q;
        cap_d     = cap_q;
        dl_vld_d  = dl_vld_q;
        dl_exp_d  = dl_exp_q;

        // Each driven bit enters the delay line; it pops out on the edge where its echo is due.
        for (int i = DL - 1; i > 0; i--) begin
            dl_vld_d[i] = dl_vld_q[i-1];
            dl_exp_d[i] = dl_exp_q[i-1];
        end
        dl_vld_d[0] = (state_q == SHIFT);
        dl_exp_d[0] = drive_q;

        if (LATENCY == 0) begin
            smp_vld = (state_q == SHIFT);
            smp_exp = drive_q;
        end else begin
            smp_vld = dl_vld_q[DL-1];
            smp_exp = dl_exp_q[DL-1];
        end

        if (smp_vld) begin
            cap_d[rx_cnt_q] = observe;
            rx_cnt_d        = rx_cnt_q + TW'(1);
            if (observe != smp_exp) begin
                err_d = err_q + CW'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d     = pattern >> 1;
                    drive_d  = pattern[0];
                    cap_d    = '0;
                    err_d    = '0;
                    pass_d   = 1'b0;
                    tx_cnt_d = '0;
                    rx_cnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                tx_cnt_d = tx_cnt_q + TW'(1);
                sr_d     = sr_q >> 1;
                if (tx_cnt_q == TW'(WIDTH - 1)) begin
                    drive_d   = 1'b0;
                    drn_cnt_d = '0;
                    if (LATENCY > 0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = DONE;
                        pass_d  = (err_d == '0);
                    end
                end else begin
                    drive_d = sr_q[0];
                end
            end
            DRAIN: begin
                drn_cnt_d = drn_cnt_q + 3'd1;
                if (drn_cnt_q == 3'(LATENCY - 1)) begin
                    state_d = DONE;
                    pass_d  = (err_d == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            drn_cnt_q <= '0;
            dl_vld_q  <= '0;
            dl_exp_q  <= '0;
            drive_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            cap_q     <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            drn_cnt_q <= drn_cnt_d;
            dl_vld_q  <= dl_vld_d;
            dl_exp_q  <= dl_exp_d;
            drive_q   <= drive_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            cap_q     <= cap_d;
        end
    end

    assign drive     = drive_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign captured  = cap_q;

endmodule

// File: tb/tb_onenet_loopback_checker.sv
// Two checkers (LATENCY 0 and 2) each closed through a selectable return path.
module tb_onenet_loopback_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start2;
    logic [7:0] pat0, pat2;
    logic       drive0, drive2, observe0, observe2;
    logic       busy0, busy2, done0, done2, pass0, pass2;
    logic [3:0] err0, err2;
    logic [7:0] cap0, cap2;

    // Return path modes: 0 wire, 1 inverter, 2 stuck at 0, 3 two-flop delay.
    logic [1:0] mode0, mode2;
    logic       d0_q1, d0_q2, d2_q1, d2_q2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] cap;
        logic [3:0] err;
        logic       pass;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];

    typedef struct {
        int         sel;
        logic [1:0] mode;
        logic [7:0] pat;
        logic [7:0] cap;
        logic [3:0] err;
        logic       pass;
        int         inj;
    } vec_t;

    vec_t tbl[11];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        d0_q1 <= drive0;
        d0_q2 <= d0_q1;
        d2_q1 <= drive2;
        d2_q2 <= d2_q1;
    end

    always_comb begin
        case (mode0)
            2'd0:    observe0 = drive0;
            2'd1:    observe0 = ~drive0;
            2'd2:    observe0 = 1'b0;
            default: observe0 = d0_q2;
        endcase
        case (mode2)
            2'd0:    observe2 = drive2;
            2'd1:    observe2 = ~drive2;
            2'd2:    observe2 = 1'b0;
            default: observe2 = d2_q2;
        endcase
    end

    onenet_loopback_checker #(.WIDTH(8), .LATENCY(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .pattern(pat0),
        .drive(drive0), .observe(observe0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(err0), .captured(cap0)
    );

    onenet_loopback_checker #(.WIDTH(8), .LATENCY(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .pattern(pat2),
        .drive(drive2), .observe(observe2), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(err2), .captured(cap2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard side: every done pulse consumes one queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL u0_unexpected_done: got done=1 expected no done at %0t", $time);
            end else begin
                e = q0.pop_front();
                chk("u0_captured", cap0, e.cap);
                chk("u0_err_count", err0, e.err);
                chk("u0_pass", pass0, e.pass);
            end
        end
        if (done2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL u2_unexpected_done: got done=1 expected no done at %0t", $time);
            end else begin
                e = q2.pop_front();
                chk("u2_captured", cap2, e.cap);
                chk("u2_err_count", err2, e.err);
                chk("u2_pass", pass2, e.pass);
            end
        end
    end

    function automatic logic busy_of(input int sel);
        return (sel != 0) ? busy2 : busy0;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel != 0) ? done2 : done0;
    endfunction

    task automatic set_in(input int sel, input logic st, input logic [7:0] p);
        if (sel != 0) begin
            start2 = st;
            pat2   = p;
        end else begin
            start0 = st;
            pat0   = p;
        end
    endtask

    // inj > 0: pulse start with 8'hFF in that cycle after E0; inj < 0: raise start in the DONE cycle.
    task automatic run(input vec_t v);
        int   lat;
        int   n;
        bit   found;
        exp_t e;
        lat   = (v.sel != 0) ? 2 : 0;
        found = 1'b0;
        @(negedge clk);
        if (v.sel != 0) mode2 = v.mode;
        else            mode0 = v.mode;
        repeat (3) @(negedge clk);
        e = '{cap: v.cap, err: v.err, pass: v.pass};
        if (v.sel != 0) q2.push_back(e);
        else            q0.push_back(e);
        set_in(v.sel, 1'b1, v.pat);
        @(negedge clk);
        set_in(v.sel, 1'b0, v.pat);
        n = 1;
        chk("busy_rise", busy_of(v.sel), 1);
        while (!found && n < 40) begin
            if (done_of(v.sel) === 1'b1) begin
                found = 1'b1;
            end else begin
                if (v.inj > 0 && n == v.inj)          set_in(v.sel, 1'b1, 8'hFF);
                else if (v.inj > 0 && n == v.inj + 1) set_in(v.sel, 1'b0, v.pat);
                @(negedge clk);
                n++;
            end
        end
        chk("done_seen", found, 1);
        if (found) begin
            chk("done_cycle", n, 9 + lat);
            chk("busy_in_done", busy_of(v.sel), 0);
            if (v.inj < 0) set_in(v.sel, 1'b1, 8'hFF);
            @(negedge clk);
            set_in(v.sel, 1'b0, v.pat);
            chk("done_one_cycle", done_of(v.sel), 0);
            chk("idle_after_done", busy_of(v.sel), 0);
            @(negedge clk);
            chk("idle_after_done2", busy_of(v.sel), 0);
        end
    endtask

    initial begin
        vec_t fresh;
        tbl[0]  = '{sel: 0, mode: 2'd0, pat: 8'hA5, cap: 8'hA5, err: 4'd0, pass: 1'b1, inj: 0};
        tbl[1]  = '{sel: 0, mode: 2'd1, pat: 8'hA5, cap: 8'h5A, err: 4'd8, pass: 1'b0, inj: 0};
        tbl[2]  = '{sel: 0, mode: 2'd2, pat: 8'hFF, cap: 8'h00, err: 4'd8, pass: 1'b0, inj: 0};
        tbl[3]  = '{sel: 0, mode: 2'd2, pat: 8'h00, cap: 8'h00, err: 4'd0, pass: 1'b1, inj: 0};
        tbl[4]  = '{sel: 0, mode: 2'd3, pat: 8'h3C, cap: 8'hF0, err: 4'd4, pass: 1'b0, inj: 0};
        tbl[5]  = '{sel: 1, mode: 2'd3, pat: 8'h3C, cap: 8'h3C, err: 4'd0, pass: 1'b1, inj: 0};
        tbl[6]  = '{sel: 1, mode: 2'd0, pat: 8'h3C, cap: 8'h0F, err: 4'd4, pass: 1'b0, inj: 0};
        tbl[7]  = '{sel: 0, mode: 2'd0, pat: 8'hA5, cap: 8'hA5, err: 4'd0, pass: 1'b1, inj: 4};
        tbl[8]  = '{sel: 0, mode: 2'd0, pat: 8'hA5, cap: 8'hA5, err: 4'd0, pass: 1'b1, inj: -1};
        tbl[9]  = '{sel: 0, mode: 2'd1, pat: 8'h00, cap: 8'hFF, err: 4'd8, pass: 1'b0, inj: 0};
        tbl[10] = '{sel: 1, mode: 2'd1, pat: 8'hC3, cap: 8'hCF, err: 4'd2, pass: 1'b0, inj: 0};

        rst_n  = 1'b0;
        start0 = 1'b0;
        start2 = 1'b0;
        pat0   = 8'h00;
        pat2   = 8'h00;
        mode0  = 2'd0;
        mode2  = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_drive0", drive0, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_pass0", pass0, 0);
        chk("rst_err0", err0, 0);
        chk("rst_cap0", cap0, 0);
        chk("rst_busy2", busy2, 0);
        chk("rst_cap2", cap2, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run(tbl[i]);
        end

        // Abort a run with reset in SHIFT cycle 4; no done may follow.
        @(negedge clk);
        mode0 = 2'd1;
        repeat (3) @(negedge clk);
        start0 = 1'b1;
        pat0   = 8'hA5;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_drive", drive0, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_done", done0, 0);
        chk("midrst_pass", pass0, 0);
        chk("midrst_err", err0, 0);
        chk("midrst_cap", cap0, 0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_still_idle", busy0, 0);

        fresh = '{sel: 0, mode: 2'd0, pat: 8'h5A, cap: 8'h5A, err: 4'd0, pass: 1'b1, inj: 0};
        run(fresh);

        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
